// File: rtl/irq_pkg.sv
// irq_pkg: shared types and defaults for the interrupt source controller.
package irq_pkg;
    typedef enum logic [1:0] {IDLE, ASSERT, WAIT_ACK} irq_state_t;
    typedef enum logic {SRC_KEY, SRC_ETH} irq_src_t;
    localparam int KEY_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/irq_eth_fifo.sv
// irq_eth_fifo: synchronous FIFO for received Ethernet words.
module irq_eth_fifo #(
    parameter int DATA_W = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] ONE = 1;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0] wp, rp;
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign head = mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + ONE;
            if (pop && !empty) rp <= rp + ONE;
        end
    end
endmodule

// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl: serialises key and Ethernet events into one acknowledged
// interrupt at a time, re-pulsing when the handler does not acknowledge in time.
module irq_source_ctrl
    import irq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int KEY_W = KEY_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [KEY_W-1:0]  key_data,
    input  logic              eth_valid,
    input  logic [DATA_W-1:0] eth_data,
    output logic              eth_ready,
    input  logic              int_ack,
    output logic              interrupt_key,
    output logic              interrupt_eth,
    output logic [DATA_W-1:0] interrupt_source_data,
    output logic              key_dropped,
    output logic              busy
);
    localparam int CW = $clog2(ACK_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE = 1;
    irq_state_t state, state_n;
    irq_src_t sel, sel_n;
    logic [DATA_W-1:0] data_n, head;
    logic [CW-1:0] cnt, cnt_n;
    logic [KEY_W-1:0] key_code;
    logic key_pending, full, empty, push, retire, key_clear, pop;
    assign eth_ready = !rst && !full;
    assign push = eth_valid && eth_ready;
    assign retire = int_ack && state != IDLE;
    assign key_clear = retire && sel == SRC_KEY;
    assign pop = retire && sel == SRC_ETH;
    assign interrupt_key = state == ASSERT && sel == SRC_KEY;
    assign interrupt_eth = state == ASSERT && sel == SRC_ETH;
    assign busy = state != IDLE;
    irq_eth_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .din(eth_data), .pop(pop),
        .head(head), .full(full), .empty(empty)
    );
    always_comb begin
        state_n = state;
        sel_n = sel;
        data_n = interrupt_source_data;
        cnt_n = cnt;
        case (state)
            IDLE: begin
                if (key_pending) begin
                    state_n = ASSERT;
                    sel_n = SRC_KEY;
                    data_n = DATA_W'(key_code);
                end else if (!empty) begin
                    state_n = ASSERT;
                    sel_n = SRC_ETH;
                    data_n = head;
                end
            end
            ASSERT: begin
                state_n = int_ack ? IDLE : WAIT_ACK;
                cnt_n = '0;
            end
            WAIT_ACK: begin
                // ack takes precedence over a simultaneous timeout
                if (int_ack) state_n = IDLE;
                else if (cnt == CNT_LAST) state_n = ASSERT;
                else cnt_n = cnt + CNT_ONE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel <= SRC_KEY;
            interrupt_source_data <= '0;
            cnt <= '0;
            key_pending <= 1'b0;
            key_code <= '0;
            key_dropped <= 1'b0;
        end else begin
            state <= state_n;
            sel <= sel_n;
            interrupt_source_data <= data_n;
            cnt <= cnt_n;
            key_dropped <= key_valid && key_pending && !key_clear;
            if (key_valid && (!key_pending || key_clear)) begin
                key_pending <= 1'b1;
                key_code <= key_data;
            end else if (key_clear) begin
                key_pending <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_irq_source_ctrl.sv
// tb_irq_source_ctrl: directed vector table plus hand-written multi-cycle sequences.
module tb_irq_source_ctrl;
    logic clk = 1'b0, rst = 1'b1, key_valid = 1'b0, eth_valid = 1'b0, int_ack = 1'b0;
    logic [7:0] key_data = '0;
    logic [31:0] eth_data = '0, interrupt_source_data;
    logic eth_ready, interrupt_key, interrupt_eth, key_dropped, busy;
    int cmp = 0, err = 0;

    irq_source_ctrl dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_data(key_data),
        .eth_valid(eth_valid), .eth_data(eth_data), .eth_ready(eth_ready),
        .int_ack(int_ack), .interrupt_key(interrupt_key), .interrupt_eth(interrupt_eth),
        .interrupt_source_data(interrupt_source_data), .key_dropped(key_dropped), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, kv;
        logic [7:0] kd;
        logic ev;
        logic [31:0] ed;
        logic ack, ik, ie;
        logic [31:0] d;
        logic dchk, kdr, bsy, er;
    } vec_t;

    vec_t tv[25];

    function automatic vec_t v(input logic r, kv, input logic [7:0] kd, input logic ev,
                               input logic [31:0] ed, input logic ack, ik, ie,
                               input logic [31:0] d, input logic dchk, kdr, bsy, er);
        vec_t x;
        x.rst = r; x.kv = kv; x.kd = kd; x.ev = ev; x.ed = ed; x.ack = ack;
        x.ik = ik; x.ie = ie; x.d = d; x.dchk = dchk; x.kdr = kdr; x.bsy = bsy; x.er = er;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        cmp++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic seen, stable;
        // columns: rst kv kd ev ed ack | ik ie data dchk kdrop busy eth_ready
        tv[0]  = v(1, 0, 8'h00, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 0, 0);
        tv[1]  = v(0, 0, 8'h00, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 0, 1);
        tv[2]  = v(0, 1, 8'h5A, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 0, 1);
        tv[3]  = v(0, 0, 8'h00, 0, 32'h0, 0, 1, 0, 32'h5A, 1, 0, 1, 1);
        tv[4]  = v(0, 0, 8'h00, 0, 32'h0, 0, 0, 0, 32'h5A, 1, 0, 1, 1);
        tv[5]  = tv[4];
        tv[6]  = tv[4];
        tv[7]  = tv[4];
        tv[8]  = v(0, 0, 8'h00, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0, 1);
        tv[9]  = v(0, 0, 8'h00, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 1);
        tv[10] = v(0, 1, 8'h11, 1, 32'hDEADBEEF, 0, 0, 0, 32'h0, 0, 0, 0, 1);
        tv[11] = v(0, 0, 8'h00, 0, 32'h0, 0, 1, 0, 32'h11, 1, 0, 1, 1);
        tv[12] = v(0, 0, 8'h00, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0, 1);
        tv[13] = v(0, 0, 8'h00, 0, 32'h0, 0, 0, 1, 32'hDEADBEEF, 1, 0, 1, 1);
        tv[14] = v(0, 0, 8'h00, 0, 32'h0, 0, 0, 0, 32'hDEADBEEF, 1, 0, 1, 1);
        tv[15] = v(0, 0, 8'h00, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0, 1);
        tv[16] = v(0, 0, 8'h00, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 1);
        tv[17] = v(0, 1, 8'hAA, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 1);
        tv[18] = v(0, 0, 8'h00, 0, 32'h0, 0, 1, 0, 32'hAA, 1, 0, 1, 1);
        tv[19] = v(0, 1, 8'hBB, 0, 32'h0, 0, 0, 0, 32'hAA, 1, 1, 1, 1);
        tv[20] = v(0, 0, 8'h00, 0, 32'h0, 0, 0, 0, 32'hAA, 1, 0, 1, 1);
        tv[21] = v(0, 1, 8'hCC, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0, 1);
        tv[22] = v(0, 0, 8'h00, 0, 32'h0, 0, 1, 0, 32'hCC, 1, 0, 1, 1);
        tv[23] = v(0, 0, 8'h00, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0, 1);
        tv[24] = tv[16];

        #2;
        for (int i = 0; i < 25; i++) begin
            rst = tv[i].rst; key_valid = tv[i].kv; key_data = tv[i].kd;
            eth_valid = tv[i].ev; eth_data = tv[i].ed; int_ack = tv[i].ack;
            step();
            check($sformatf("vec%0d flags(ik,ie,kdrop,busy,rdy)", i),
                  {interrupt_key, interrupt_eth, key_dropped, busy, eth_ready},
                  {tv[i].ik, tv[i].ie, tv[i].kdr, tv[i].bsy, tv[i].er});
            if (tv[i].dchk) check($sformatf("vec%0d data", i), interrupt_source_data, tv[i].d);
        end
        key_valid = 0; int_ack = 0;

        // FIFO full: four words fill it, a fifth is refused, order preserved
        eth_valid = 1;
        for (int w = 1; w <= 4; w++) begin
            eth_data = w;
            step();
        end
        check("fifo_full_ready", eth_ready, 0);
        eth_data = 5;
        step();
        step();
        check("fifo_full_ready_hold", eth_ready, 0);
        eth_valid = 0;
        for (int w = 1; w <= 4; w++) begin
            for (int k = 0; k < 10 && !busy; k++) step();
            check($sformatf("fifo_busy%0d", w), busy, 1);
            check($sformatf("fifo_order%0d", w), interrupt_source_data, w);
            int_ack = 1;
            step();
            int_ack = 0;
            check($sformatf("fifo_retire%0d", w), busy, 0);
            if (w == 1) check("fifo_ready_after_pop", eth_ready, 1);
        end
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            seen |= busy;
        end
        check("fifo_fifth_dropped", seen, 0);

        // Timeout: re-pulse every ACK_TIMEOUT+1 cycles, same payload
        eth_valid = 1; eth_data = 32'h77;
        step();
        eth_valid = 0;
        for (int k = 0; k < 10 && !interrupt_eth; k++) step();
        check("to_first_pulse", interrupt_eth, 1);
        for (int r = 0; r < 2; r++) begin
            n = 0; stable = 1;
            do begin
                step();
                n++;
                if (interrupt_source_data !== 32'h77 || interrupt_key) stable = 0;
            end while (!interrupt_eth && n < 200);
            check($sformatf("to_period%0d", r), n, 65);
            check($sformatf("to_stable%0d", r), stable, 1);
        end
        int_ack = 1;
        step();
        int_ack = 0;
        check("to_ack_retire", busy, 0);
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            seen |= interrupt_eth | interrupt_key | busy;
        end
        check("to_quiet", seen, 0);

        // Reset in WAIT_ACK with two words queued
        eth_valid = 1; eth_data = 32'hA;
        step();
        eth_data = 32'hB;
        step();
        eth_valid = 0;
        step();
        step();
        check("rst_pre_busy", busy, 1);
        rst = 1;
        step();
        check("rst_flags", {interrupt_key, interrupt_eth, key_dropped, busy, eth_ready}, 0);
        check("rst_data", interrupt_source_data, 0);
        rst = 0;
        #1;
        check("rst_ready", eth_ready, 1);
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            seen |= interrupt_eth | interrupt_key | busy;
        end
        check("rst_quiet", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
